// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int SKID_DEPTH         = 3;
  localparam int LEVEL_W            = 2;
  localparam int PTR_W              = 2;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // Pointers run 0..SKID_DEPTH-1, so they wrap 2->0 rather than at a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Three-entry skid buffer: register file with head/tail pointers and an occupancy count.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output level_t                o_count
);

  logic [DATA_WIDTH-1:0] entry_q [SKID_DEPTH];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  level_t                count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    count_d = count_q;
    head_d  = i_pop  ? ptr_inc(head_q) : head_q;
    tail_d  = i_push ? ptr_inc(tail_q) : tail_q;
    if (i_push && !i_pop) begin
      count_d = level_t'(count_q + 1'b1);
    end else if (!i_push && i_pop) begin
      count_d = level_t'(count_q - 1'b1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the entries are reset because o_data must read zero out of reset; a larger array would not be.
      for (int i = 0; i < SKID_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (i_push) begin
        entry_q[tail_q] <= i_data;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_data  = entry_q[head_q];
  assign o_count = count_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the async FIFO's registered read port into a valid/ready stream via a 3-entry skid buffer.
// Define FIFO_RD_ADAPTER_LAST_EN to generate o_m_last every PKT_LEN beats; otherwise o_m_last is 0.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PKT_LEN    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_fifo_rd_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  output logic [LEVEL_W-1:0]    o_level
);

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_rd_stream_adapter: PKT_LEN must be >= 1");
  end

  logic             inflight_q;
  level_t           count;
  logic             pop;
  logic [LEVEL_W:0] occupancy;

  // Issue depends only on registered state, keeping i_m_ready off the FIFO read path.
  assign occupancy    = {1'b0, count} + {{LEVEL_W{1'b0}}, inflight_q};
  assign o_fifo_rd_en = !i_rst && !i_fifo_empty && (occupancy < (LEVEL_W + 1)'(SKID_DEPTH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= o_fifo_rd_en;
    end
  end

  assign o_m_valid = (count != '0);
  assign pop       = o_m_valid && i_m_ready;
  assign o_level   = count;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (inflight_q),
    .i_pop   (pop),
    .i_data  (i_fifo_rd_data),
    .o_data  (o_m_data),
    .o_count (count)
  );

`ifdef FIFO_RD_ADAPTER_LAST_EN
  localparam int BEAT_W = $clog2(PKT_LEN) + 1;

  logic [BEAT_W-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (pop) begin
      beat_d = (beat_q == BEAT_W'(PKT_LEN - 1)) ? '0 : BEAT_W'(beat_q + 1'b1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign o_m_last = o_m_valid && (beat_q == BEAT_W'(PKT_LEN - 1));
`else
  assign o_m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural registered-read FIFO and in-order scoreboard.
module tb_fifo_rd_stream_adapter;

  localparam int DW  = 64;
  localparam int PKT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    level;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PKT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_rd_data (fifo_rd_data),
    .o_m_valid      (m_valid),
    .i_m_ready      (m_ready),
    .o_m_data       (m_data),
    .o_m_last       (m_last),
    .o_level        (level)
  );

  // Behavioural FIFO read side: data appears the cycle after an accepted read.
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          block_empty;
  logic          fifo_clr;

  assign fifo_empty = (rd_ptr == wr_ptr) || block_empty;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= 0;
    end else if (rd_en) begin
      fifo_rd_data <= mem[rd_ptr[9:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q [$];
  bit            mon_en;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            beats;
  int            valid_hi;
  int            lasts;
  int            max_level;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic exp_last;
    if (!mon_en) return;
    if (prev_stall) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
      check("hold_last", m_last, prev_last);
    end
    if (m_valid) begin
      valid_hi++;
`ifdef FIFO_RD_ADAPTER_LAST_EN
      exp_last = ((beats % PKT) == PKT - 1);
`else
      exp_last = 1'b0;
`endif
      check("last", m_last, exp_last);
      if (m_ready) begin
        if (m_last) lasts++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("data", m_data, exp_q.pop_front());
        beats++;
      end
    end else begin
      check("last_idle", m_last, 0);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    beats      = 0;
    valid_hi   = 0;
    lasts      = 0;
    prev_stall = 0;
    max_level  = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    fifo_clr    = 1'b1;
    wr_ptr      = 0;
    block_empty = 1'b1;
    m_ready     = 1'b0;
    mon_en      = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    fifo_clr = 1'b0;
    clear_monitor();
    mon_en   = 1'b1;
  endtask

  task automatic load_word(input logic [DW-1:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  task automatic drain(input int bound, input string tag);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      tick();
      i++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int last_seen;

    // Reset values, and no read issued while reset is held even with data present
    rst         = 1'b1;
    fifo_clr    = 1'b1;
    block_empty = 1'b1;
    m_ready     = 1'b0;
    mon_en      = 1'b0;
    clear_monitor();
    repeat (2) @(posedge clk);
    #1;
    for (int v = 1; v <= 32; v++) load_word(DW'(v));
    block_empty = 1'b0;
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    block_empty = 1'b1;
    rst         = 1'b0;
    fifo_clr    = 1'b0;
    @(posedge clk);
    #1;
    check("rd_en_blocked", rd_en, 0);

    // Streaming: latency 2, then 32 gapless beats with level <= 1
    m_ready     = 1'b1;
    block_empty = 1'b0;
    mon_en      = 1'b1;
    #1;
    check("stream_rd_en_c0", rd_en, 1);
    check("stream_valid_c0", m_valid, 0);
    tick();
    check("stream_valid_c1", m_valid, 0);
    tick();
    check("stream_valid_c2", m_valid, 1);
    max_level = 0;
    repeat (32) tick();
    check("stream_beats", beats, 32);
    check("stream_no_gap", exp_q.size(), 0);
    check("stream_max_level", max_level <= 1, 1);

    // Backpressure: fill to 3, stop reading, hold 0xA0
    do_reset();
    for (int v = 'hA0; v <= 'hA9; v++) load_word(DW'(v));
    block_empty = 1'b0;
    repeat (10) tick();
    check("bp_level", level, 3);
    check("bp_rd_en", rd_en, 0);
    check("bp_reads", rd_ptr, 3);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 'hA0);
    m_ready = 1'b1;
    drain(40, "bp_drain");
    check("bp_beats", beats, 10);

    // Random ready and random empty over 1000 words
    do_reset();
    for (int i = 0; i < 1000; i++) load_word({$urandom(), $urandom()});
    for (int i = 0; i < 8000 && exp_q.size() != 0; i++) begin
      m_ready     = 1'($urandom_range(0, 1));
      block_empty = ($urandom_range(0, 3) == 0);
      tick();
    end
    check("rand_drained", exp_q.size(), 0);
    check("rand_beats", beats, 1000);

    // Empty mid-stream: exactly two beats then valid stays low
    do_reset();
    load_word('h1111);
    load_word('h2222);
    m_ready     = 1'b1;
    block_empty = 1'b0;
    repeat (10) tick();
    check("empty_beats", beats, 2);
    check("empty_valid_cycles", valid_hi, 2);
    check("empty_valid", m_valid, 0);
    check("empty_level", level, 0);

    // Reset with count=2 and one word inflight
    do_reset();
    for (int v = 0; v < 10; v++) load_word(DW'('h10 + v));
    block_empty = 1'b0;
    repeat (3) tick();
    check("mid_level", level, 2);
    check("mid_rd_en", rd_en, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_data", m_data, 0);
    mon_en   = 1'b0;
    fifo_clr = 1'b1;
    wr_ptr   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    fifo_clr = 1'b0;
    clear_monitor();
    mon_en   = 1'b1;
    load_word('h55);
    m_ready  = 1'b1;
    #1;
    check("mid_rd_en_after", rd_en, 1);
    drain(10, "mid_drain");
    check("mid_beats", beats, 1);

    // Packet boundaries: 12 beats with a one-cycle stall on each boundary beat
    do_reset();
    for (int v = 0; v < 12; v++) load_word(DW'('hC0 + v));
    block_empty = 1'b0;
    last_seen   = -1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      if (m_valid && (beats % PKT) == PKT - 1 && beats != last_seen) begin
        m_ready   = 1'b0;
        last_seen = beats;
      end else begin
        m_ready = 1'b1;
      end
      tick();
    end
    check("pkt_drained", exp_q.size(), 0);
`ifdef FIFO_RD_ADAPTER_LAST_EN
    check("pkt_lasts", lasts, 3);
`else
    check("pkt_lasts", lasts, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
